// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the frame-sequencer state encoding, requester ids and a counter-width helper.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } sched_state_e;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter2.sv
// Two-way round-robin pick with its last-grant register.
// The pick is purely combinational; the history only moves when a byte is actually taken.
module uart_rr_arbiter2
    import uart_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       take_i,
    output logic       pick_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        pick_o = REQ_HOST;
        if (valid_i == 2'b10) begin
            pick_o = REQ_AUX;
        end else if (valid_i == 2'b11) begin
            pick_o = ~last_grant_q;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (take_i) begin
            last_grant_d = pick_o;
        end
    end

    // Starts as if the aux side was served last so the host wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= REQ_AUX;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two byte sources onto one UART transmit interface and sequences one frame per byte.
// A watchdog aborts frames the UART never starts (CTS held off).
//
// state     | meaning
// IDLE      | waiting for an accepted byte
// REQ       | first cycle of the start request
// WAIT_BUSY | start held high until the UART reports busy; watchdog running
// WAIT_DONE | frame in flight, waiting for the done pulse
// GAP       | enforced idle spacing after a frame
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int CTS_TIMEOUT = 1_000_000,
    parameter int GAP_CYCLES  = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_in,
    input  logic             req0_valid_in,
    input  logic [7:0]       req0_data_in,
    output logic             req0_ready_out,
    input  logic             req1_valid_in,
    input  logic [7:0]       req1_data_in,
    output logic             req1_ready_out,
    output logic [7:0]       uart_tx_data_out,
    output logic             uart_start_tx_out,
    input  logic             uart_tx_busy_in,
    input  logic             uart_tx_done_in,
    output logic             grant_id_out,
    output logic             sched_busy_out,
    output logic             timeout_err_out,
    output logic [CNT_W-1:0] frames_sent_out
);

    localparam int WD_W = cnt_width(CTS_TIMEOUT);
    localparam int GP_W = cnt_width(GAP_CYCLES);
    localparam logic [WD_W-1:0] WD_TC    = WD_W'(CTS_TIMEOUT);
    localparam logic [GP_W-1:0] GAP_LOAD = GP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam sched_state_e    AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

    sched_state_e     state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             grant_q, grant_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [GP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0] frames_q, frames_d;

    logic            take;
    logic            pick;
    logic            start_tx;
    logic            abort;
    logic [WD_W-1:0] wdog_inc;

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign take = (state_q == IDLE) & enable_in & (req0_valid_in | req1_valid_in) & ~rst;

    uart_rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_i ({req1_valid_in, req0_valid_in}),
        .take_i  (take),
        .pick_o  (pick)
    );

    assign req0_ready_out = take & (pick == REQ_HOST);
    assign req1_ready_out = take & (pick == REQ_AUX);

    assign wdog_inc = (wdog_q == WD_TC) ? wdog_q : wdog_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        grant_d  = grant_q;
        wdog_d   = wdog_q;
        gap_d    = gap_q;
        frames_d = frames_q;
        start_tx = 1'b0;
        abort    = 1'b0;

        case (state_q)
            IDLE: begin
                if (take) begin
                    data_d  = (pick == REQ_AUX) ? req1_data_in : req0_data_in;
                    grant_d = pick;
                    wdog_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                start_tx = 1'b1;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                start_tx = 1'b1;
                wdog_d   = wdog_inc;
                if (uart_tx_busy_in) begin
                    state_d = WAIT_DONE;
                end else if (uart_tx_done_in) begin
                    // Busy was too short to see; the done pulse still completes the frame.
                    frames_d = frames_q + 1'b1;
                    gap_d    = GAP_LOAD;
                    state_d  = AFTER_FRAME;
                end else if (wdog_inc == WD_TC) begin
                    abort   = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = AFTER_FRAME;
                end
            end
            WAIT_DONE: begin
                if (uart_tx_done_in) begin
                    frames_d = frames_q + 1'b1;
                    gap_d    = GAP_LOAD;
                    state_d  = AFTER_FRAME;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            grant_q  <= 1'b0;
            wdog_q   <= '0;
            gap_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            wdog_q   <= wdog_d;
            gap_q    <= gap_d;
            frames_q <= frames_d;
        end
    end

    // Start is decoded from the state register alone, so an async reset removes it at once.
    assign uart_start_tx_out = start_tx;
    assign timeout_err_out   = abort;
    assign uart_tx_data_out  = data_q;
    assign grant_id_out      = grant_q;
    assign sched_busy_out    = (state_q != IDLE);
    assign frames_sent_out   = frames_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized traffic,
// compared cycle by cycle against a frame-schedule model computed from arithmetic.
module tb_uart_tx_scheduler;

    localparam int T = 20;
    localparam int G = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_in;
    logic        req0_valid_in, req1_valid_in;
    logic [7:0]  req0_data_in, req1_data_in;
    logic        req0_ready_out, req1_ready_out;
    logic [7:0]  uart_tx_data_out;
    logic        uart_start_tx_out;
    logic        uart_tx_busy_in, uart_tx_done_in;
    logic        grant_id_out, sched_busy_out, timeout_err_out;
    logic [15:0] frames_sent_out;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.CTS_TIMEOUT(T), .GAP_CYCLES(G), .CNT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable_in         (enable_in),
        .req0_valid_in     (req0_valid_in),
        .req0_data_in      (req0_data_in),
        .req0_ready_out    (req0_ready_out),
        .req1_valid_in     (req1_valid_in),
        .req1_data_in      (req1_data_in),
        .req1_ready_out    (req1_ready_out),
        .uart_tx_data_out  (uart_tx_data_out),
        .uart_start_tx_out (uart_start_tx_out),
        .uart_tx_busy_in   (uart_tx_busy_in),
        .uart_tx_done_in   (uart_tx_done_in),
        .grant_id_out      (grant_id_out),
        .sched_busy_out    (sched_busy_out),
        .timeout_err_out   (timeout_err_out),
        .frames_sent_out   (frames_sent_out)
    );

    int tests = 0;
    int fails = 0;

    // requester queues and per-cycle valid masks
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit m0 = 1'b1, m1 = 1'b1;
    bit cur_v0, cur_v1;

    // frame schedule model: accept cycle, busy delay/length, timeout flag, end cycle
    int  cyc = 0;
    bit  fr = 1'b0;
    int  fa, fe, fbd, fbl;
    bit  fto;
    int  nbd = 2, nbl = 4;
    bit  nnever = 1'b0;
    bit  lastg = 1'b1;
    logic [7:0]  xdata = 8'h00;
    logic        xgid = 1'b0;
    logic [15:0] xframes = 16'h0;

    // observations of the DUT
    int  n_start, n_rdy0, n_rdy1, n_to;
    logic prev_start = 1'b0;
    logic [7:0] log_data[$];
    logic       log_gid[$];
    int  done_cyc[$];
    int  acc_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        int c;
        cur_v0 = (q0.size() > 0) && m0;
        cur_v1 = (q1.size() > 0) && m1;
        req0_valid_in = cur_v0;
        req1_valid_in = cur_v1;
        req0_data_in  = cur_v0 ? q0[0] : 8'h00;
        req1_data_in  = cur_v1 ? q1[0] : 8'h00;
        c = fa + 1;
        if (fr && !fto) begin
            uart_tx_busy_in = (fbl > 0) && (cyc >= c + fbd) && (cyc < c + fbd + fbl);
            uart_tx_done_in = (cyc == c + fbd + fbl);
        end else begin
            uart_tx_busy_in = 1'b0;
            uart_tx_done_in = 1'b0;
        end
    endtask

    task automatic step();
        bit idle, pick, r0, r1, xs, xto;
        int send;
        drive_inputs();
        #1;
        idle = !fr;
        pick = (cur_v0 && cur_v1) ? !lastg : cur_v1;
        r0   = idle && (enable_in === 1'b1) && cur_v0 && !pick;
        r1   = idle && (enable_in === 1'b1) && cur_v1 && pick;
        send = fto ? fa + 1 + T : fa + 1 + fbd;
        xs   = fr && (cyc <= send);
        xto  = fr && fto && (cyc == fe);

        chk("ready0",     32'(req0_ready_out),    32'(r0));
        chk("ready1",     32'(req1_ready_out),    32'(r1));
        chk("start_tx",   32'(uart_start_tx_out), 32'(xs));
        chk("timeout",    32'(timeout_err_out),   32'(xto));
        chk("sched_busy", 32'(sched_busy_out),    32'(fr));
        chk("tx_data",    32'(uart_tx_data_out),  32'(xdata));
        chk("grant_id",   32'(grant_id_out),      32'(xgid));
        chk("frames",     32'(frames_sent_out),   32'(xframes));

        if (uart_start_tx_out === 1'b1 && prev_start !== 1'b1) begin
            log_data.push_back(uart_tx_data_out);
            log_gid.push_back(grant_id_out);
        end
        prev_start = uart_start_tx_out;
        if (uart_start_tx_out === 1'b1) n_start++;
        if (req0_ready_out === 1'b1) n_rdy0++;
        if (req1_ready_out === 1'b1) n_rdy1++;
        if (timeout_err_out === 1'b1) n_to++;
        if (uart_tx_done_in) done_cyc.push_back(cyc);
        if (req0_ready_out === 1'b1 || req1_ready_out === 1'b1) acc_cyc.push_back(cyc);

        if (fr && cyc == fe && !fto) xframes = xframes + 16'd1;
        if (fr && cyc == fe + G) fr = 1'b0;
        if (r0 || r1) begin
            fr  = 1'b1;
            fa  = cyc;
            fbd = nbd;
            fbl = nbl;
            fto = nnever;
            fe  = fto ? fa + 1 + T : ((fbl > 0) ? fa + 1 + fbd + fbl : fa + 1 + fbd);
            xdata = r0 ? q0.pop_front() : q1.pop_front();
            xgid  = r1;
            lastg = r1;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while ((fr || q0.size() > 0 || q1.size() > 0) && k < maxc) begin
            step();
            k++;
        end
        chk("drain_bound", 32'(k < maxc), 32'd1);
    endtask

    task automatic clear_obs();
        n_start = 0; n_rdy0 = 0; n_rdy1 = 0; n_to = 0;
        log_data.delete(); log_gid.delete(); done_cyc.delete(); acc_cyc.delete();
    endtask

    initial begin
        logic [7:0] exp_d[4];
        logic       exp_g[4];
        int k;

        rst = 1'b1;
        enable_in = 1'b0;
        req0_valid_in = 1'b0; req1_valid_in = 1'b0;
        req0_data_in = 8'h00; req1_data_in = 8'h00;
        uart_tx_busy_in = 1'b0; uart_tx_done_in = 1'b0;
        clear_obs();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_start",  32'(uart_start_tx_out), 32'd0);
        chk("rst_busy",   32'(sched_busy_out),    32'd0);
        chk("rst_data",   32'(uart_tx_data_out),  32'd0);
        chk("rst_frames", 32'(frames_sent_out),   32'd0);
        rst = 1'b0;
        enable_in = 1'b1;

        // both requesters contend: strict alternation starting with req0
        q0.push_back(8'h11); q0.push_back(8'h11);
        q1.push_back(8'h22); q1.push_back(8'h22);
        nbd = 2; nbl = 4;
        drain(200);
        exp_d = '{8'h11, 8'h22, 8'h11, 8'h22};
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        chk("rr_count", 32'(log_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            chk("rr_data", 32'(log_data[i]), 32'(exp_d[i]));
            chk("rr_gid",  32'(log_gid[i]),  32'(exp_g[i]));
        end

        // single byte, busy 3 cycles after start, done 10 cycles later
        clear_obs();
        q0.push_back(8'hA5);
        nbd = 3; nbl = 10;
        drain(100);
        chk("t1_ready_pulses", 32'(n_rdy0), 32'd1);
        chk("t1_start_cycles", 32'(n_start), 32'd4);
        chk("t1_data", 32'(log_data[0]), 32'hA5);
        chk("t1_gid",  32'(log_gid[0]), 32'd0);
        chk("t1_frames", 32'(frames_sent_out), 32'd5);

        // CTS held off: watchdog abort, then recovery
        clear_obs();
        nnever = 1'b1;
        q1.push_back(8'h3C);
        drain(100);
        nnever = 1'b0;
        chk("t3_to_pulses", 32'(n_to), 32'd1);
        chk("t3_start_cycles", 32'(n_start), 32'(T + 1));
        chk("t3_frames", 32'(frames_sent_out), 32'd5);
        clear_obs();
        nbd = 1; nbl = 3;
        q0.push_back(8'h4D);
        drain(100);
        chk("t3_recover_data", 32'(log_data[0]), 32'h4D);
        chk("t3_recover_frames", 32'(frames_sent_out), 32'd6);

        // back-to-back frames: idle spacing after done
        clear_obs();
        q0.push_back(8'h01); q0.push_back(8'h02);
        nbd = 1; nbl = 3;
        drain(100);
        chk("t4_acc_count", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() >= 2 && done_cyc.size() >= 1)
            chk("t4_gap_cycles", 32'(acc_cyc[1] - done_cyc[0] - 1), 32'(G));
        chk("t4_frames", 32'(frames_sent_out), 32'd8);

        // enable dropped mid-frame
        clear_obs();
        q0.push_back(8'h81);
        nbd = 1; nbl = 8;
        k = 0;
        step();
        while (!(fr && cyc == fa + 1 + fbd + 2) && k < 50) begin
            step();
            k++;
        end
        chk("t5_reach_wait_done", 32'(k < 50), 32'd1);
        enable_in = 1'b0;
        q1.push_back(8'h82);
        n_rdy0 = 0; n_rdy1 = 0;
        repeat (25) step();
        chk("t5_no_ready", 32'(n_rdy0 + n_rdy1), 32'd0);
        chk("t5_frames_done", 32'(frames_sent_out), 32'd9);
        enable_in = 1'b1;
        drain(100);
        chk("t5_resume_data", 32'(log_data[log_data.size() - 1]), 32'h82);
        chk("t5_frames_resume", 32'(frames_sent_out), 32'd10);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 4) q0.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0 && q1.size() < 4) q1.push_back(8'($urandom));
            m0 = ($urandom_range(0, 3) != 0);
            m1 = ($urandom_range(0, 3) != 0);
            enable_in = ($urandom_range(0, 7) != 0);
            nbd = $urandom_range(1, 4);
            nbl = $urandom_range(0, 6);
            nnever = ($urandom_range(0, 15) == 0);
            step();
        end
        m0 = 1'b1; m1 = 1'b1; enable_in = 1'b1; nnever = 1'b0;
        drain(600);

        // async reset while waiting for busy
        clear_obs();
        nnever = 1'b1;
        q0.push_back(8'h99);
        k = 0;
        step();
        while (!(fr && cyc == fa + 5) && k < 50) begin
            step();
            k++;
        end
        chk("t7_reach_wait_busy", 32'(k < 50), 32'd1);
        q0.push_back(8'h5A);
        q1.push_back(8'h6B);
        drive_inputs();
        #1;
        chk("t7_start_before", 32'(uart_start_tx_out), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t7_start_async", 32'(uart_start_tx_out), 32'd0);
        chk("t7_busy",   32'(sched_busy_out),   32'd0);
        chk("t7_data",   32'(uart_tx_data_out), 32'd0);
        chk("t7_gid",    32'(grant_id_out),     32'd0);
        chk("t7_frames", 32'(frames_sent_out),  32'd0);
        chk("t7_ready0", 32'(req0_ready_out),   32'd0);
        chk("t7_ready1", 32'(req1_ready_out),   32'd0);
        chk("t7_to",     32'(timeout_err_out),  32'd0);
        @(posedge clk);
        #1;
        chk("t7_start_held", 32'(uart_start_tx_out), 32'd0);
        rst = 1'b0;
        cyc++;
        fr = 1'b0; lastg = 1'b1; xdata = 8'h00; xgid = 1'b0; xframes = 16'h0;
        nnever = 1'b0; nbd = 2; nbl = 2;
        prev_start = 1'b0;
        clear_obs();
        drain(100);
        chk("t7_first_gid",  32'(log_gid[0]),  32'd0);
        chk("t7_first_data", 32'(log_data[0]), 32'h5A);
        chk("t7_frames_after", 32'(frames_sent_out), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
